// File: rtl/tank_sensor_filter.sv
// tank_sensor_filter
//   Conditions the two raw level sensors of a tank before they reach the tank
//   controller. Each raw sensor is synchronised (2 flops) and debounced: a
//   change is accepted only after DEBOUNCE_CYCLES consecutive cycles of
//   disagreement with the current clean value. A fault FSM watches the clean
//   pair for the physically impossible "upper wet, lower dry" combination; if
//   it persists past FAULT_CYCLES the block declares a fault and forces both
//   outputs high (tank-full indication, pumps off downstream).
//
//   Parameters
//     DEBOUNCE_CYCLES  stability count to accept a sensor change (2..255)
//     FAULT_CYCLES     inconsistent-pair count before fault (1..255)
//   Ports
//     clk    in   single clock, rising edge
//     reset  in   synchronous, active-high reset
//     I_raw  in   raw lower-level sensor (1 = water present), asynchronous
//     S_raw  in   raw upper-level sensor (1 = water present), asynchronous
//     I      out  filtered lower sensor (forced 1 in fault)
//     S      out  filtered upper sensor (forced 1 in fault)
//     fault  out  sensor-fault indication (decoded from the state register)
//   Build option
//     TANK_FAULT_LATCH_EN  when defined, FAULT is sticky until reset; when
//                          undefined, FAULT clears on the first consistent pair.

module tank_sensor_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FAULT_CYCLES    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic I_raw,
  input  logic S_raw,
  output logic I,
  output logic S,
  output logic fault
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] FC_LAST = 8'(FAULT_CYCLES);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  logic       i_sync1, i_sync2, s_sync1, s_sync2;
  logic       i_clean, s_clean;
  logic [7:0] i_cnt, s_cnt;

  state_t     state_q, state_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       inconsistent;

  // Two-flop synchronisers for both raw inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      i_sync1 <= 1'b0;
      i_sync2 <= 1'b0;
      s_sync1 <= 1'b0;
      s_sync2 <= 1'b0;
    end else begin
      i_sync1 <= I_raw;
      i_sync2 <= i_sync1;
      s_sync1 <= S_raw;
      s_sync2 <= s_sync1;
    end
  end

  // Lower-sensor debounce: counter runs only while sync disagrees with clean,
  // and any re-match drops it back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_clean <= 1'b0;
      i_cnt   <= '0;
    end else if (i_sync2 == i_clean) begin
      i_cnt <= '0;
    end else if (i_cnt == DB_LAST) begin
      i_clean <= i_sync2;
      i_cnt   <= '0;
    end else begin
      i_cnt <= i_cnt + 8'd1;
    end
  end

  // Upper-sensor debounce, independent of the lower channel
  always_ff @(posedge clk) begin
    if (reset) begin
      s_clean <= 1'b0;
      s_cnt   <= '0;
    end else if (s_sync2 == s_clean) begin
      s_cnt <= '0;
    end else if (s_cnt == DB_LAST) begin
      s_clean <= s_sync2;
      s_cnt   <= '0;
    end else begin
      s_cnt <= s_cnt + 8'd1;
    end
  end

  assign inconsistent = s_clean & ~i_clean;

  // Fault FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OK;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Fault FSM: next state. The counter enters SUSPECT at 1 and FAULT is taken
  // when it already equals FAULT_CYCLES, so FAULT_CYCLES==1 gives exactly one
  // SUSPECT cycle.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      ST_OK: begin
        if (inconsistent) begin
          state_d = ST_SUSPECT;
          fcnt_d  = 8'd1;
        end
      end
      ST_SUSPECT: begin
        if (!inconsistent) begin
          state_d = ST_OK;
          fcnt_d  = '0;
        end else if (fcnt_q == FC_LAST) begin
          state_d = ST_FAULT;
        end else begin
          fcnt_d = fcnt_q + 8'd1;
        end
      end
      ST_FAULT: begin
`ifdef TANK_FAULT_LATCH_EN
        state_d = ST_FAULT;
`else
        if (!inconsistent) begin
          state_d = ST_OK;
          fcnt_d  = '0;
        end
`endif
      end
      default: begin
        state_d = ST_OK;
        fcnt_d  = '0;
      end
    endcase
  end

  // Fault FSM: outputs. Clean registers keep tracking while outputs are forced.
  always_comb begin
    fault = (state_q == ST_FAULT);
    I     = fault ? 1'b1 : i_clean;
    S     = fault ? 1'b1 : s_clean;
  end

endmodule
